// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants used by the receiver, the RX FIFO and other UART
// blocks.
//   UART_DATA_W       : width of one UART character (receiver DQ width)
//   UART_RXFIFO_DEPTH : default number of entries in the receive FIFO
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_RXFIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_edge_rise.sv
// -----------------------------------------------------------------------------
// uart_edge_rise
// Single-cycle rising-edge detector on a level input. The delay register has a
// configurable reset value. With RST_VAL=1, a level that is already high when
// reset releases is not reported as an edge.
// Ports:
//   clk     : clock
//   rst_n   : synchronous reset, active-low
//   level_i : level to watch
//   rise_o  : one-cycle strobe in the first cycle level_i is seen high
// -----------------------------------------------------------------------------
module uart_edge_rise #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  // Delay register holding the previous level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= RST_VAL;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule : uart_edge_rise

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. It pushes rx_dq once per rising edge
// of rx_end into a circular FIFO. The host side reads through a show-ahead
// valid/ready port. The block also reports occupancy, full/empty and a sticky
// overflow flag.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   rx_end     : frame-complete level from the receiver
//   rx_dq      : received byte, stable while rx_end is high
//   rd_data    : head-of-FIFO byte (0 while empty)
//   rd_valid   : FIFO non-empty
//   rd_ready   : consumer takes rd_data this cycle
//   count      : occupancy 0..DEPTH
//   full/empty : count==DEPTH / count==0
//   overflow   : sticky, a byte was dropped because the FIFO was full
//   ovf_clr    : clears overflow (an overflow in the same cycle wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = UART_DATA_W,
  parameter  int DEPTH  = UART_RXFIFO_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_end,
  input  logic [DATA_W-1:0] rx_dq,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;

  logic push_s;
  logic pop_s;
  logic accept_s;
  logic ovf_set_s;

  // rx_end delay register resets high, so a level already high at reset
  // release is not treated as a new frame.
  uart_edge_rise #(
    .RST_VAL (1'b1)
  ) u_rx_end_rise (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (rx_end),
    .rise_o  (push_s)
  );

  assign pop_s = rd_valid_q & rd_ready;
  // When full, a pop in the same cycle frees the slot the push needs.
  assign accept_s  = push_s & (~full_q | pop_s);
  assign ovf_set_s = push_s & full_q & ~pop_s;

  // Next-state for pointers, occupancy and status flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == CNT_W'(0));
    rd_valid_d = ~empty_d;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= rx_dq;
    end
  end

  assign rd_data  = rd_valid_q ? mem_q[rd_ptr_q] : '0;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Scoreboard bench for uart_rx_fifo (DATA_W=8, DEPTH=16). A reference process
// models accepted pushes and queues the expected bytes. A negedge monitor pops
// the queue on every read handshake and compares data and status. Directed
// checks cover the hand-computed points of each scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_end;
  logic [7:0] rx_dq;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  int         m_cnt  = 0;
  logic       m_prev = 1'b1;
  logic       m_ovf  = 1'b0;
  logic       mon_en = 1'b0;

  uart_rx_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_end   (rx_end),
    .rx_dq    (rx_dq),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decides acceptance of each push and queues accepted bytes.
  always @(posedge clk) begin
    logic push, pop, acc;
    if (!rst_n) begin
      m_prev = 1'b1;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      exp_q.delete();
    end else begin
      push   = rx_end & ~m_prev;
      m_prev = rx_end;
      pop    = (m_cnt != 0) && rd_ready;
      acc    = push && ((m_cnt < DEPTH) || pop);
      if (push && !acc) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (acc) exp_q.push_back(rx_dq);
      m_cnt = m_cnt + int'(acc) - int'(pop);
    end
  end

  // Monitor: compares status every cycle and the head byte on each handshake.
  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en) begin
      check("mon_count",    32'(count),    32'(m_cnt));
      check("mon_rd_valid", 32'(rd_valid), 32'(m_cnt != 0));
      check("mon_full",     32'(full),     32'(m_cnt == DEPTH));
      check("mon_empty",    32'(empty),    32'(m_cnt == 0));
      check("mon_overflow", 32'(overflow), 32'(m_ovf));
      if (m_cnt != 0 && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("mon_queue_underrun", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("mon_rd_data", 32'(rd_data), 32'(e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input int hold);
    rx_dq  = b;
    rx_end = 1'b1;
    repeat (hold) step();
    rx_end = 1'b0;
    step();
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_end   = 1'b1;
    rx_dq    = 8'h00;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;

    // Reset with rx_end held high across release: no push.
    repeat (3) step();
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (3) step();
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    rx_end = 1'b0;
    step();

    // Two held-high frames give exactly two entries.
    push_byte(8'hA5, 3);
    push_byte(8'h3C, 3);
    check("two_count",   32'(count),   32'd2);
    check("two_head",    32'(rd_data), 32'hA5);
    rd_ready = 1'b1;
    repeat (2) step();
    rd_ready = 1'b0;
    check("two_empty",   32'(empty),   32'd1);

    // Fill to 16, then one overflowing push of FF.
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd16);
    push_byte(8'hFF, 1);
    check("ovf_set",    32'(overflow), 32'd1);
    check("ovf_count",  32'(count),    32'd16);

    // Clear overflow.
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Push 55 while full and popping in the same cycle.
    rx_dq    = 8'h55;
    rx_end   = 1'b1;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    rx_end   = 1'b0;
    step();
    check("simul_count", 32'(count),    32'd16);
    check("simul_ovf",   32'(overflow), 32'd0);
    check("simul_head",  32'(rd_data),  32'h01);
    rd_ready = 1'b1;
    repeat (16) step();
    rd_ready = 1'b0;
    check("simul_drained", 32'(empty), 32'd1);

    // Interleaved traffic across several pointer wraps.
    for (int i = 0; i < 40; i++) begin
      rd_ready = ((i % 3) != 0);
      push_byte(8'(8'h80 + i), 1);
    end
    rd_ready = 1'b1;
    repeat (20) step();
    rd_ready = 1'b0;
    check("mix_drained", 32'(empty), 32'd1);

    // Overflowing push coinciding with ovf_clr: the set wins.
    for (int i = 0; i < 16; i++) push_byte(8'(8'hE0 + i), 1);
    rx_dq   = 8'h77;
    rx_end  = 1'b1;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    rx_end  = 1'b0;
    step();
    check("ovf_win_flag",  32'(overflow), 32'd1);
    check("ovf_win_count", 32'(count),    32'd16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_win_clr", 32'(overflow), 32'd0);
    rd_ready = 1'b1;
    repeat (20) step();
    rd_ready = 1'b0;

    // Reset with five entries stored.
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i), 1);
    check("pre_rst_count", 32'(count), 32'd5);
    rst_n = 1'b0;
    step();
    check("mid_rst_count",    32'(count),    32'd0);
    check("mid_rst_empty",    32'(empty),    32'd1);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    check("post_rst_empty", 32'(empty), 32'd1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver. It watches the receiver's frame-complete level (RX_END) and its parallel byte (DQ), and pushes one byte per rising edge of RX_END into a circular FIFO. Bytes are presented to the host or bus side through a show-ahead valid/ready read port. The block reports occupancy, full/empty status and a sticky overflow flag.

Parameters:
DATA_W, 8, byte width; must match the receiver's DQ width.
DEPTH, 16, number of entries; power of two, minimum 2.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridable).

Ports:
clk  input  1  system clock; the same clk that drives the receiver.
rst_n  input  1  synchronous reset, active-low.
rx_end  input  1  frame-complete level from the receiver.
rx_dq  input  DATA_W  received byte from the receiver; stable while rx_end is high.
rd_data  output  DATA_W  head-of-FIFO byte; valid when rd_valid=1.
rd_valid  output  1  FIFO non-empty.
rd_ready  input  1  consumer accepts rd_data this cycle.
count  output  CNT_W  current occupancy, 0..DEPTH.
full  output  1  count==DEPTH.
empty  output  1  count==0.
overflow  output  1  sticky flag: a byte was dropped.
ovf_clr  input  1  clears overflow.

Behaviour:
- Reset, when rst_n=0 at a clk edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, overflow=0, rx_end_q=1. Storage contents are don't-care. rd_data=0 while empty.
- rx_end_q resets to 1, so an rx_end level that is already high when reset releases does not produce a push.
- Push strobe: push = rx_end & ~rx_end_q, where rx_end_q is rx_end registered. This gives exactly one push per rising edge. A held-high rx_end produces no further pushes.
- rx_dq is sampled in the same cycle as push, i.e. the first cycle in which rx_end is seen high.
- Pop: pop = rd_valid & rd_ready. rd_ready while empty has no effect.
- Write latency: a byte pushed at edge N gives rd_valid=1 and rd_data equal to that byte after edge N.
- Read data is show-ahead: rd_data always shows mem[rd_ptr] while rd_valid=1. After a pop at edge N, the next entry appears after edge N.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count is a separate counter:
  - +1 on an accepted push without a pop.
  - -1 on a pop without an accepted push.
  - unchanged when both or neither occur.
- Simultaneous push and pop:
  - Not full: both proceed and count is unchanged.
  - Full: the pop frees a slot in the same cycle, so the push is accepted. count stays at DEPTH and overflow is not set.
  - Empty: the push is accepted and the pop is ignored (rd_valid=0). count becomes 1.
- Overflow: a push while full with no pop drops the byte. Storage, pointers and count are unchanged, and overflow is set to 1 at the next edge. It stays set until ovf_clr=1.
- If ovf_clr=1 and an overflowing push occur in the same cycle, the set wins and overflow remains 1.
- full, empty and rd_valid are registered, derived from the next-state count, and update on the same edge as count.
- A reset asserted mid-operation discards all contents on that edge, whatever push or pop is active.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 8, used by the receiver and this block.
  - UART_RXFIFO_DEPTH default.
- One natural sub-module: uart_edge_rise (clk, rst_n, level_i, rise_o, with a configurable reset value for the delay register). It is reusable for the TX-done strobe later.
- The storage array and pointer logic stay inline.

Test Plan:
- Reset with rx_end held at 1 and released -> no push. count=0, empty=1, rd_valid=0, overflow=0.
- rx_end pulses (low->high, held 3 cycles) with rx_dq=8'hA5, then 8'h3C, rd_ready=0 -> exactly 2 entries, count=2. With rd_ready=1, rd_data reads A5 then 3C on consecutive cycles, then empty=1.
- Push 16 bytes 8'h00..8'h0F with DEPTH=16 -> full=1, count=16. A 17th push of 8'hFF -> overflow=1, count=16, readback gives 00..0F and no FF.
- Full FIFO, push 8'h55 in the same cycle as a pop -> count stays 16, overflow=0, and 8'h55 is read last after 01..0F.
- 40 push/pop cycles of interleaved traffic spanning several pointer wraps -> read order equals write order, and count never exceeds 16 or underflows.
- overflow=1, then ovf_clr pulse -> overflow=0 next cycle. ovf_clr coinciding with a new overflowing push -> overflow stays 1. Assert rst_n=0 with 5 entries stored -> count=0, empty=1 after that edge.
